// File: rtl/mips_mem_pkg.sv
// Shared types and helpers for the MIPS data-memory initiator.
// Provides access size / error / FSM state enums, byte-enable generation,
// raw size decoding and the alignment check.
package mips_mem_pkg;

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned WADDR_W = 30;
    localparam int unsigned BE_W    = 4;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } size_e;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'd0,
        ERR_ALIGN   = 2'd1,
        ERR_TIMEOUT = 2'd2
    } err_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_e;

    // Raw request size; encoding 3 is folded onto word.
    function automatic size_e decode_size(input logic [1:0] raw);
        case (raw)
            2'd0:    decode_size = SZ_BYTE;
            2'd1:    decode_size = SZ_HALF;
            default: decode_size = SZ_WORD;
        endcase
    endfunction

    // Big-endian lanes: byte offset 0 is enable bit 3 (bits [31:24]).
    function automatic logic [BE_W-1:0] byte_enables(input size_e size, input logic [1:0] offset);
        case (size)
            SZ_BYTE: byte_enables = 4'b1000 >> offset;
            SZ_HALF: byte_enables = offset[1] ? 4'b0011 : 4'b1100;
            default: byte_enables = 4'b1111;
        endcase
    endfunction

    function automatic logic is_misaligned(input size_e size, input logic [1:0] offset);
        case (size)
            SZ_BYTE: is_misaligned = 1'b0;
            SZ_HALF: is_misaligned = offset[0];
            default: is_misaligned = (offset != 2'b00);
        endcase
    endfunction

endpackage

// File: rtl/mips_load_align.sv
// Load data extraction: selects the addressed byte/half from a big-endian
// memory word and zero- or sign-extends it to 32 bits.
// Ports: mem_data (raw word), offset (addr[1:0]), size, sign_ext -> result_c.
module mips_load_align
    import mips_mem_pkg::*;
(
    input  logic [DATA_W-1:0] mem_data,
    input  logic [1:0]        offset,
    input  size_e             size,
    input  logic              sign_ext,
    output logic [DATA_W-1:0] result_c
);

    // Move the addressed lane to the top so byte/half are always [31:24]/[31:16].
    logic [DATA_W-1:0] shifted;
    assign shifted = mem_data << {offset, 3'b000};

    always_comb begin
        result_c = '0;
        case (size)
            SZ_BYTE: result_c = {{24{sign_ext & shifted[31]}}, shifted[31:24]};
            SZ_HALF: result_c = {{16{sign_ext & shifted[31]}}, shifted[31:16]};
            default: result_c = shifted;
        endcase
    end

endmodule

// File: rtl/mips_dmem_initiator.sv
// CPU-side data-memory master: accepts one byte-addressed load/store, drives
// the word-addressed bus until DataMem_Ready, then returns a one-cycle response
// with aligned/extended load data and an error code (misaligned / timeout).
// Ports: clock, reset_n; req_* request channel (req_ready high only when idle);
// rsp_* response channel; DataMem_* memory bus.
module mips_dmem_initiator
    import mips_mem_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_write,
    input  logic [1:0]          req_size,
    input  logic                req_signed,
    input  logic [31:0]         req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    output logic                rsp_valid,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic [1:0]          rsp_error,
    input  logic [DATA_W-1:0]   DataMem_In,
    input  logic                DataMem_Ready,
    output logic                DataMem_Read,
    output logic [BE_W-1:0]     DataMem_Write,
    output logic [WADDR_W-1:0]  DataMem_Address,
    output logic [DATA_W-1:0]   DataMem_Out
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               write_q, write_d;
    size_e              size_q, size_d;
    logic               signed_q, signed_d;
    logic [31:0]        addr_q, addr_d;
    logic [DATA_W-1:0]  wdata_q, wdata_d;
    logic [DATA_W-1:0]  rdata_q, rdata_d;
    err_e               error_q, error_d;

    logic [DATA_W-1:0]  load_c;
    logic [BE_W-1:0]    lane_be;
    logic               in_access;

    mips_load_align u_align (
        .mem_data (DataMem_In),
        .offset   (addr_q[1:0]),
        .size     (size_q),
        .sign_ext (signed_q),
        .result_c (load_c)
    );

    // State and request/response registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            write_q  <= 1'b0;
            size_q   <= SZ_BYTE;
            signed_q <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            error_q  <= ERR_NONE;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            write_q  <= write_d;
            size_q   <= size_d;
            signed_q <= signed_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            error_q  <= error_d;
        end
    end

    // Next-state, capture, timeout and response logic.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        write_d  = write_q;
        size_d   = size_q;
        signed_d = signed_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        error_d  = error_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    write_d  = req_write;
                    size_d   = decode_size(req_size);
                    signed_d = req_signed;
                    addr_d   = req_addr;
                    wdata_d  = req_wdata;
                    cnt_d    = '0;
                    error_d  = ERR_NONE;
                    if (is_misaligned(decode_size(req_size), req_addr[1:0])) begin
                        state_d = ST_RESP;
                        error_d = ERR_ALIGN;
                        rdata_d = '0;
                    end else begin
                        state_d = ST_ACCESS;
                    end
                end
            end
            ST_ACCESS: begin
                if (DataMem_Ready) begin
                    state_d = ST_RESP;
                    error_d = ERR_NONE;
                    rdata_d = write_q ? '0 : load_c;
                end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    state_d = ST_RESP;
                    error_d = ERR_TIMEOUT;
                    rdata_d = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Bus strobes drop combinationally with Ready so a zero-wait slave
    // never sees the request still high at the completing edge.
    assign in_access       = (state_q == ST_ACCESS);
    assign lane_be         = byte_enables(size_q, addr_q[1:0]);
    assign DataMem_Read    = in_access && !write_q && !DataMem_Ready;
    assign DataMem_Write   = (in_access && write_q) ? (lane_be & {BE_W{!DataMem_Ready}}) : '0;
    assign DataMem_Address = addr_q[31:2];

    // Replicate store data across lanes; enables pick the live lane(s).
    always_comb begin
        DataMem_Out = '0;
        case (size_q)
            SZ_BYTE: DataMem_Out = {4{wdata_q[7:0]}};
            SZ_HALF: DataMem_Out = {2{wdata_q[15:0]}};
            default: DataMem_Out = wdata_q;
        endcase
    end

    assign req_ready = (state_q == ST_IDLE);
    assign rsp_valid = (state_q == ST_RESP);
    assign rsp_rdata = rdata_q;
    assign rsp_error = error_q;

endmodule
